unidad_busqueda: RTL and testbench
==================================

// Module: unidad_busqueda
// PURPOSE
// - Instruction-fetch stage and IF/ID pipeline register feeding unidad de control.
// - Holds the PC, runs a req/ready handshake with instruction memory, and absorbs hazard stalls.
// - Redirects on taken branches and drives OpCode/Funct to the control unit and ALU control.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset
// - PC_STEP   4              PC increment per fetched instruction
// PORTS
// - clk            in   1   single clock, rising edge
// - reset          in   1   asynchronous, active-high
// - stall          in   1   hazard unit: hold IF/ID and PC
// - branch_taken   in   1   EX: redirect fetch to branch_target, squash IF/ID
// - branch_target  in   32  redirect address; bits [1:0] forced to 0
// - imem_req       out  1   fetch request; imem_addr stable while high and !imem_ready
// - imem_addr      out  32  fetch address (= pc)
// - imem_ready     in   1   imem_rdata valid this cycle; completes request
// - imem_rdata     in   32  fetched instruction
// - if_id_valid    out  1   IF/ID holds a real instruction
// - if_id_instr    out  32  IF/ID instruction; 32'h0 (NOP) when invalid
// - if_id_pc4      out  32  address of instruction + PC_STEP
// - OpCode         out  6   if_id_instr[31:26]
// - Funct          out  6   if_id_instr[5:0]
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, state=S_IDLE. Outputs: imem_req=0, if_id_valid=0,
//   if_id_instr=0, if_id_pc4=0, OpCode=0, Funct=0.
// - imem_req=1 in S_REQ and S_DROP; 0 in S_IDLE and S_HOLD. imem_addr=pc always.
// - Priority per cycle: reset > branch_taken > stall > normal fetch.
// - S_IDLE -> S_REQ unconditionally. The first request is issued 1 cycle after reset release.
// - S_REQ:
//   - branch_taken & imem_ready: discard rdata, pc<=target, stay S_REQ.
//   - branch_taken & !imem_ready: redir_pc<=target, go S_DROP.
//   - ready & !stall: IF/ID<={rdata, pc+4}, valid<=1, pc<=pc+PC_STEP.
//   - ready & stall: buf<=rdata, go S_HOLD. IF/ID holds.
//   - !ready & !stall: bubble (valid<=0, instr<=0).
//   - !ready & stall: IF/ID holds.
// - S_HOLD: no request.
//   - branch_taken: drop buf, pc<=target, go S_REQ.
//   - !stall: IF/ID<={buf, pc+4}, valid<=1, pc<=pc+PC_STEP, go S_REQ.
// - S_DROP: the old request stays outstanding at the old pc and is completed and discarded.
//   - On ready: pc<=redir_pc, go S_REQ.
//   - A further branch_taken overwrites redir_pc (newest wins).
// - Any branch_taken cycle: IF/ID<=NOP, valid<=0 next edge, even if stall=1.
//   - IF/ID stays NOP while in S_DROP.
// - Fetch latency: ready at edge N -> if_id_valid at N. Zero-wait memory sustains 1 instr/cycle.
// - pc adds wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), no flag.
// - Reset mid-request: the request is abandoned; a late imem_ready is ignored in S_IDLE.
// STRUCTURE
// - Package: state encoding S_IDLE/S_REQ/S_HOLD/S_DROP, NOP=32'h0, field offsets OP_HI=31/OP_LO=26/FN_HI=5/FN_LO=0.
// - Sub-module registro_if_id: valid/instr/pc4 register with load, hold and squash inputs.
// - FSM, pc, redir_pc and buf stay in the top module.
// TESTING
// - Reset release, zero-wait memory returning 0x8C01_0004, 0x0022_1820 ->
//   - imem_addr 0x0, 0x4, 0x8 on consecutive cycles.
//   - OpCode 6'b100011 then 6'b000000; Funct 6'h20; if_id_pc4 0x4, 0x8.
// - Memory waits 3 cycles per fetch ->
//   - imem_addr stable for 3 cycles; if_id_valid=0 bubbles; valid pulses once per instruction.
// - stall=1 for 2 cycles when ready arrives with 0x1000_0003 -> S_HOLD, imem_req=0, IF/ID unchanged.
//   - After stall drops, IF/ID=0x1000_0003 and fetch resumes at pc+4.
// - branch_taken with target 0x0000_0041 and no outstanding wait -> next imem_addr=0x40, if_id_valid=0.
// - branch_taken to 0x100 while request to 0x8 is pending 2 more cycles ->
//   - addr stays 0x8 until ready; data discarded; next addr 0x100; no valid in between.
// - Assert reset mid-wait, then release ->
//   - Outputs go to reset values immediately; first request at 0x0 one cycle after release.

Source files
------------

// File: rtl/unidad_busqueda_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and the instruction field positions decoded for the control unit.
package unidad_busqueda_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

endpackage

// File: rtl/unidad_busqueda_registro_if_id.sv
// IF/ID pipeline register. Priority: squash > load > hold; with none asserted
// the stage takes a bubble (NOP, invalid) and keeps the last pc4.
module registro_if_id
   import unidad_busqueda_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        hold_i,
   input  logic        squash_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if (squash_i) begin
         valid_d = 1'b0;
         instr_d = NOP;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc4_d   = pc4_i;
      end else if (!hold_i) begin
         valid_d = 1'b0;
         instr_d = NOP;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= NOP;
         pc4_q   <= 32'h0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: PC, req/ready handshake with instruction memory,
// stall buffering, branch redirect and the IF/ID register feeding decode.
module unidad_busqueda
   import unidad_busqueda_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic [5:0]  OpCode,
   output logic [5:0]  Funct,
   output state_t      dbg_state_o
);

   // Handshake: a request is live while imem_req=1; imem_addr does not change
   // until the cycle imem_ready=1, which completes it with imem_rdata valid.
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] buf_q, buf_d;
   logic        ld, hold, squash;
   logic [31:0] ld_instr;
   logic [31:0] tgt;
   logic [31:0] pc_next;

   assign tgt     = branch_target & ~32'h3;
   assign pc_next = pc_q + PC_STEP;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         redir_q <= RESET_PC;
         buf_q   <= NOP;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      redir_d  = redir_q;
      buf_d    = buf_q;
      ld       = 1'b0;
      hold     = 1'b0;
      squash   = 1'b0;
      ld_instr = imem_rdata;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (branch_taken) begin
               squash = 1'b1;
               pc_d   = tgt;
            end else begin
               hold = 1'b1;
            end
         end
         S_REQ: begin
            if (branch_taken) begin
               squash = 1'b1;
               if (imem_ready) begin
                  pc_d = tgt;
               end else begin
                  redir_d = tgt;
                  state_d = S_DROP;
               end
            end else if (imem_ready && !stall) begin
               ld   = 1'b1;
               pc_d = pc_next;
            end else if (imem_ready) begin
               buf_d   = imem_rdata;
               hold    = 1'b1;
               state_d = S_HOLD;
            end else if (stall) begin
               hold = 1'b1;
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               squash  = 1'b1;
               pc_d    = tgt;
               state_d = S_REQ;
            end else if (!stall) begin
               ld       = 1'b1;
               ld_instr = buf_q;
               pc_d     = pc_next;
               state_d  = S_REQ;
            end else begin
               hold = 1'b1;
            end
         end
         S_DROP: begin
            // Old request completes at the old pc; its data is thrown away.
            squash = 1'b1;
            if (branch_taken) redir_d = tgt;
            if (imem_ready) begin
               pc_d    = branch_taken ? tgt : redir_q;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
      imem_addr   = pc_q;
      dbg_state_o = state_q;
   end

   registro_if_id u_if_id (
      .clk_i    (clk),
      .rst_i    (reset),
      .load_i   (ld),
      .hold_i   (hold),
      .squash_i (squash),
      .instr_i  (ld_instr),
      .pc4_i    (pc_next),
      .valid_o  (if_id_valid),
      .instr_o  (if_id_instr),
      .pc4_o    (if_id_pc4)
   );

   assign OpCode = if_id_instr[OP_HI:OP_LO];
   assign Funct  = if_id_instr[FN_HI:FN_LO];

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: scenario tasks plus a scoreboard that checks
// every newly loaded IF/ID entry against instructions the memory model returned.
module tb_unidad_busqueda;
   import unidad_busqueda_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [5:0]  OpCode;
   logic [5:0]  Funct;
   state_t      dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] last_instr = 32'h0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc4 = 32'h0;

   unidad_busqueda dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .OpCode        (OpCode),
      .Funct         (Funct),
      .dbg_state_o   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a fresh IF/ID entry is valid with a pc4 different from last cycle.
   always @(posedge clk) begin
      logic [63:0] e;
      #1;
      if (!reset && if_id_valid && (!prev_valid || if_id_pc4 !== prev_pc4)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected instr=%h pc4=%h with no expected entry", if_id_instr, if_id_pc4);
         end else begin
            e = exp_q.pop_front();
            if ({if_id_instr, if_id_pc4} !== e) begin
               errors++;
               $display("FAIL sb_ifid got instr=%h pc4=%h exp instr=%h pc4=%h",
                        if_id_instr, if_id_pc4, e[63:32], e[31:0]);
            end
         end
      end
      prev_valid = if_id_valid;
      prev_pc4   = if_id_pc4;
   end

   // One memory transaction at exp_pc with the given number of wait cycles.
   task automatic fetch_word(input logic [31:0] w, input int waits);
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         checks++;
         if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_addr got addr=%h req=%b exp addr=%h req=1", imem_addr, imem_req, exp_pc);
         end
         tick();
         checks++;
         if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL wait_bubble got valid=%b instr=%h exp valid=0 instr=0", if_id_valid, if_id_instr);
         end
      end
      checks++;
      if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_addr got addr=%h req=%b exp addr=%h req=1", imem_addr, imem_req, exp_pc);
      end
      imem_ready = 1'b1;
      imem_rdata = w;
      exp_q.push_back({w, exp_pc + 32'd4});
      tick();
      imem_ready = 1'b0;
      exp_pc     = exp_pc + 32'd4;
      last_instr = w;
   endtask

   // Redirect from S_REQ with the memory completing in the same cycle.
   task automatic branch_now(input logic [31:0] target, input logic st);
      branch_taken  = 1'b1;
      branch_target = target;
      stall         = st;
      imem_ready    = 1'b1;
      imem_rdata    = $urandom;
      tick();
      branch_taken = 1'b0;
      imem_ready   = 1'b0;
      stall        = 1'b0;
      exp_pc       = target & 32'hFFFF_FFFC;
      checks++;
      if (imem_addr !== exp_pc || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL branch_redirect got addr=%h valid=%b instr=%h req=%b exp addr=%h valid=0 instr=0 req=1",
                  imem_addr, if_id_valid, if_id_instr, imem_req, exp_pc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
          if_id_pc4 !== 32'h0 || OpCode !== 6'h0 || Funct !== 6'h0) begin
         errors++;
         $display("FAIL reset_values got req=%b addr=%h valid=%b instr=%h pc4=%h op=%h fn=%h exp all zero",
                  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, OpCode, Funct);
      end
      reset  = 1'b0;
      exp_pc = 32'h0;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_req got %b exp 0", imem_req);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      fetch_word(32'h8C01_0004, 0);
      checks++;
      if (OpCode !== 6'b100011 || if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL zw_first got op=%b pc4=%h valid=%b exp op=100011 pc4=4 valid=1", OpCode, if_id_pc4, if_id_valid);
      end
      fetch_word(32'h0022_1820, 0);
      checks++;
      if (OpCode !== 6'b000000 || Funct !== 6'h20 || if_id_pc4 !== 32'h8) begin
         errors++;
         $display("FAIL zw_second got op=%b fn=%h pc4=%h exp op=000000 fn=20 pc4=8", OpCode, Funct, if_id_pc4);
      end
      checks++;
      if (imem_addr !== 32'h8) begin
         errors++;
         $display("FAIL zw_addr got %h exp 8", imem_addr);
      end
   endtask

   task automatic test_wait_states();
      for (int k = 0; k < 3; k++) fetch_word($urandom, 3);
   endtask

   task automatic test_stall();
      fetch_word($urandom, 0);
      stall      = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'h1000_0003;
      for (int c = 0; c < 2; c++) begin
         tick();
         imem_ready = 1'b0;
         checks++;
         if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_instr !== last_instr || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL stall_hold c=%0d got req=%b valid=%b instr=%h addr=%h exp req=0 valid=1 instr=%h addr=%h",
                     c, imem_req, if_id_valid, if_id_instr, imem_addr, last_instr, exp_pc);
         end
      end
      stall = 1'b0;
      exp_q.push_back({32'h1000_0003, exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      tick();
      checks++;
      if (if_id_instr !== 32'h1000_0003 || if_id_valid !== 1'b1 || imem_addr !== exp_pc || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL stall_release got instr=%h valid=%b addr=%h req=%b exp instr=10000003 valid=1 addr=%h req=1",
                  if_id_instr, if_id_valid, imem_addr, imem_req, exp_pc);
      end
      fetch_word($urandom, 1);
   endtask

   task automatic test_branch();
      branch_now(32'h0000_0041, 1'b0);
      fetch_word($urandom, 0);
      branch_now(32'h0000_0083, 1'b1);
      fetch_word($urandom, 0);
   endtask

   task automatic test_branch_pending();
      branch_now(32'h0000_0008, 1'b0);
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0100;
      tick();
      branch_taken = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (imem_addr !== 32'h8 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_wait c=%0d got addr=%h req=%b valid=%b exp addr=8 req=1 valid=0",
                     c, imem_addr, imem_req, if_id_valid);
         end
         imem_ready = (c == 1);
         imem_rdata = 32'hDEAD_BEEF;
         tick();
      end
      imem_ready = 1'b0;
      exp_pc     = 32'h100;
      checks++;
      if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL drop_redirect got addr=%h valid=%b req=%b exp addr=100 valid=0 req=1",
                  imem_addr, if_id_valid, imem_req);
      end
      fetch_word($urandom, 0);
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0300;
      tick();
      branch_target = 32'h0000_0400;
      tick();
      branch_taken = 1'b0;
      imem_ready   = 1'b1;
      tick();
      imem_ready = 1'b0;
      exp_pc     = 32'h400;
      checks++;
      if (imem_addr !== 32'h400 || if_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_newest got addr=%h valid=%b exp addr=400 valid=0", imem_addr, if_id_valid);
      end
      fetch_word($urandom, 2);
   endtask

   task automatic test_wrap();
      branch_now(32'hFFFF_FFFC, 1'b0);
      fetch_word($urandom, 0);
      checks++;
      if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap got addr=%h pc4=%h exp addr=0 pc4=0", imem_addr, if_id_pc4);
      end
   endtask

   task automatic test_reset_mid();
      fetch_word(32'h2345_6789, 0);
      stall = 1'b1;
      tick();
      #2;
      reset      = 1'b1;
      imem_ready = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
          if_id_pc4 !== 32'h0 || OpCode !== 6'h0) begin
         errors++;
         $display("FAIL async_reset got req=%b addr=%h valid=%b instr=%h pc4=%h op=%h exp all zero",
                  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, OpCode);
      end
      stall = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      imem_ready = 1'b0;
      exp_pc     = 32'h0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_late_ready got req=%b addr=%h valid=%b exp req=1 addr=0 valid=0",
                  imem_req, imem_addr, if_id_valid);
      end
      fetch_word(32'h8C01_0004, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_branch();
      test_branch_pending();
      test_wrap();
      test_reset_mid();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d pending entries exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
